payment_dispenser: RTL and testbench
====================================

# payment_dispenser

Payment-side controller for the drink vending machine. Accepts coins, accumulates credit, and completes a purchase once a drink is selected and credit covers its cost. Then it pulses the dispense output and pays out change one unit at a time. It takes the registered drink selection and the 3-bit cost produced by the selection/cost path, and it drives its own credit display and status LEDs.

## Interface
- `CREDIT_W`, default 4: credit register width. The maximum credit is 2^CREDIT_W−1.
- `DISPENSE_CYCLES`, default 4: number of cycles `dispense` is held high per purchase.
- `TIMEOUT_CYCLES`, default 50_000_000: inactivity limit. Used only with `PAYMENT_TIMEOUT_EN`.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `coin` in 2: coin code, valid for one cycle per coin. 00 = none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- `sel_valid` in 1: a drink is currently selected (registered selection is nonzero).
- `cost` in 3: price of the selected drink, 0–7 units.
- `cancel` in 1: level request to refund all credit.
- `credit` out CREDIT_W: current credit.
- `dispense` out 1: high while the drink is released.
- `change_pulse` out 1: one-cycle pulse per unit of change returned.
- `reject` out 1: one-cycle pulse when a coin is refused.
- `busy` out 1: high in DISPENSE and CHANGE.
- `display` out 7: 7-segment digit of `credit` (hex 0–F), active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE: `credit` = 0. A nonzero `coin` loads its value and moves to COLLECT.
- COLLECT: evaluated each cycle in strict priority order.
  1. `cancel`=1 → CHANGE; the whole credit is refunded.
  2. `sel_valid`=1 and `cost`≠0 and `credit`≥`cost` → DISPENSE, with `credit` ← `credit`−`cost`.
  3. Nonzero `coin` → `credit` ← `credit`+value.
- Saturation: if `credit`+value > 2^CREDIT_W−1, the coin is refused. `reject` pulses and `credit` is unchanged.
- Any coin arriving in a cycle where rule 1 or 2 fires is refused and `reject` pulses.
- `cost`=0 never triggers a purchase.
- DISPENSE: `dispense` is high for exactly DISPENSE_CYCLES cycles. Then the FSM goes to CHANGE if `credit`>0, otherwise to IDLE.
- CHANGE: alternates pulse and gap cycles.
  - Pulse cycle: `change_pulse`=1 and `credit` decrements by 1.
  - Gap cycle: `change_pulse`=0.
  - After the gap that follows the pulse taking `credit` to 0, the FSM returns to IDLE.
- In DISPENSE and CHANGE, every nonzero `coin` is refused (`reject` pulse). `cancel` and `sel_valid` are ignored.
- `busy` = state is DISPENSE or CHANGE. `display` = decode of `credit`.

## Timing
- All outputs are registered. `display` is registered from the next-state credit, so it matches `credit` in the same cycle.
- Reset values: state IDLE, `credit`=0, `dispense`=0, `change_pulse`=0, `reject`=0, `busy`=0, `display`=7'b1000000 ("0").
- Coin sampled at edge N → `credit` updated after edge N, visible in cycle N+1. `reject` is high in cycle N+1 for exactly one cycle.
- Purchase condition sampled at edge N → `dispense` and `busy` are high in cycles N+1 … N+DISPENSE_CYCLES.
- First `change_pulse` comes in the cycle after the last `dispense` cycle, or the cycle after `cancel` is sampled.
- Change pulses are spaced 2 cycles apart. Refunding k units takes 2k cycles, then IDLE.
- `rst` asserted mid-operation immediately clears all state and outputs to their reset values; the credit is lost. Release is synchronous to `clk` upstream.

## Configuration
- `PAYMENT_TIMEOUT_EN` defined:
  - A counter runs only in COLLECT.
  - It clears on any accepted coin and on entry to COLLECT.
  - If TIMEOUT_CYCLES consecutive cycles pass with no coin accepted, the FSM enters CHANGE and refunds all credit, as if `cancel` were asserted.
- `PAYMENT_TIMEOUT_EN` undefined: no counter exists, and COLLECT holds credit indefinitely.

## Test plan
- Reset: release `rst` → all outputs at reset values and `display`=7'b1000000. Then coin 10 → `credit`=2 and `display`=7'b0100100.
- Exact pay: coins 01,10 (credit 3), then `sel_valid`=1 with `cost`=3 → `dispense` high for 4 cycles, no `change_pulse`, back to IDLE with `credit`=0.
- Overpay: coin 11 (credit 5), then `cost`=2 with `sel_valid` → 4 `dispense` cycles, then 3 `change_pulse` pulses 2 cycles apart, final `credit`=0.
- Saturation and collisions:
  - Credit 14, then coin 10 → `reject` pulse and `credit` stays 14.
  - Coin 01 in the same cycle as a valid purchase → `reject` pulse and the coin is not credited.
  - Coin during CHANGE → `reject` pulse.
- Cancel and reset: credit 7, then `cancel` → 7 change pulses over 14 cycles. In a second run, assert `rst` in the middle of DISPENSE → outputs clear immediately.
- With `PAYMENT_TIMEOUT_EN` and TIMEOUT_CYCLES=10: coin 10, then idle for 10 cycles → refund of 2 pulses, then IDLE. Undefined: credit is held for 100 cycles.

Source files
------------

// File: rtl/payment_dispenser.sv
// Payment controller for the vending machine: coin credit, purchase, dispense pulse, paced change.
// Optional inactivity refund is compiled in with `define PAYMENT_TIMEOUT_EN.
module payment_dispenser #(
  parameter int unsigned CREDIT_W        = 4,
  parameter int unsigned DISPENSE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [2:0]          cost,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_pulse,
  output logic                reject,
  output logic                busy,
  output logic [6:0]          display
);

  localparam int unsigned SUM_W  = CREDIT_W + 1;
  localparam int unsigned CMP_W  = CREDIT_W + 3;
  localparam int unsigned DISP_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  if (DISPENSE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("payment_dispenser: DISPENSE_CYCLES and TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [DISP_W-1:0]   disp_cnt, disp_cnt_nxt;
  logic                dispense_nxt, change_pulse_nxt, reject_nxt, busy_nxt;
  logic [6:0]          display_nxt;
  logic [SUM_W-1:0]    coin_val, sum;
  logic                buy, refund, coin_accept, tmo_hit;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    case (coin)
      2'b01:   coin_val = SUM_W'(1);
      2'b10:   coin_val = SUM_W'(2);
      2'b11:   coin_val = SUM_W'(5);
      default: coin_val = '0;
    endcase
  end

  assign sum    = SUM_W'(credit) + coin_val;
  assign buy    = sel_valid && (cost != 3'd0) && (CMP_W'(credit) >= CMP_W'(cost));
  assign refund = cancel || tmo_hit;
  // A coin is credited only when nothing higher priority fires and it does not overflow.
  assign coin_accept = (coin != 2'b00) &&
                       ((state == S_IDLE) ||
                        ((state == S_COLLECT) && !refund && !buy && !sum[CREDIT_W]));

`ifdef PAYMENT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == S_COLLECT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) &&
                   !((coin != 2'b00) && !sum[CREDIT_W]);

  // Counts consecutive COLLECT cycles without an accepted coin; zero on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state != S_COLLECT || state_nxt != S_COLLECT || coin_accept) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State, credit and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      credit       <= '0;
      disp_cnt     <= '0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      reject       <= 1'b0;
      busy         <= 1'b0;
      display      <= 7'b1000000;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      disp_cnt     <= disp_cnt_nxt;
      dispense     <= dispense_nxt;
      change_pulse <= change_pulse_nxt;
      reject       <= reject_nxt;
      busy         <= busy_nxt;
      display      <= display_nxt;
    end
  end

  // Next state and credit.
  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    disp_cnt_nxt = disp_cnt;
    case (state)
      S_IDLE: begin
        credit_nxt = '0;
        if (coin != 2'b00) begin
          credit_nxt = CREDIT_W'(coin_val);
          state_nxt  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (refund) begin
          state_nxt  = S_CHANGE;
          credit_nxt = credit - CREDIT_W'(1);
        end else if (buy) begin
          state_nxt    = S_DISPENSE;
          credit_nxt   = credit - CREDIT_W'(cost);
          disp_cnt_nxt = '0;
        end else if (coin_accept) begin
          credit_nxt = sum[CREDIT_W-1:0];
        end
      end
      S_DISPENSE: begin
        if (disp_cnt == DISP_W'(DISPENSE_CYCLES - 1)) begin
          if (credit != '0) begin
            state_nxt  = S_CHANGE;
            credit_nxt = credit - CREDIT_W'(1);
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          disp_cnt_nxt = disp_cnt + DISP_W'(1);
        end
      end
      default: begin
        // Gap cycle: issue the next unit, or finish once the last pulse has had its gap.
        if (!change_pulse) begin
          if (credit == '0) state_nxt = S_IDLE;
          else              credit_nxt = credit - CREDIT_W'(1);
        end
      end
    endcase
  end

  // Output values, registered alongside the state.
  always_comb begin
    dispense_nxt     = (state_nxt == S_DISPENSE);
    busy_nxt         = (state_nxt == S_DISPENSE) || (state_nxt == S_CHANGE);
    change_pulse_nxt = (state_nxt == S_CHANGE) && ((state != S_CHANGE) || !change_pulse);
    reject_nxt       = (coin != 2'b00) && !coin_accept;
    display_nxt      = seg7(4'(credit_nxt));
  end

endmodule

// File: tb/tb_payment_dispenser.sv
// Scoreboard bench for payment_dispenser: expected busy/reject cycles are queued by the stimulus
// and popped by an independent monitor on the falling edge.
module tb_payment_dispenser;

  typedef struct packed {
    logic       busy;
    logic       disp;
    logic       cp;
    logic       rej;
    logic [3:0] credit;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_valid;
  logic [2:0] cost;
  logic       cancel;
  logic [3:0] credit;
  logic       dispense, change_pulse, reject, busy;
  logic [6:0] display;

  ev_t q[$];
  ev_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  payment_dispenser #(.CREDIT_W(4), .DISPENSE_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .cost(cost), .cancel(cancel),
    .credit(credit), .dispense(dispense), .change_pulse(change_pulse), .reject(reject),
    .busy(busy), .display(display)
  );

  function automatic logic [6:0] seg_exp(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  // Monitor: every cycle with busy or reject must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && (busy || reject)) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got busy=%b disp=%b cp=%b rej=%b credit=%0d, none expected",
                   busy, dispense, change_pulse, reject, credit);
        end else begin
          mon_e = q.pop_front();
          if ({busy, dispense, change_pulse, reject, credit, display} !==
              {mon_e, seg_exp(mon_e.credit)}) begin
            n_fail++;
            $display("FAIL event @%0t: got busy=%b disp=%b cp=%b rej=%b credit=%0d seg=%h, expected busy=%b disp=%b cp=%b rej=%b credit=%0d seg=%h",
                     $time, busy, dispense, change_pulse, reject, credit, display,
                     mon_e.busy, mon_e.disp, mon_e.cp, mon_e.rej, mon_e.credit, seg_exp(mon_e.credit));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic d, input logic c, input logic r, input logic [3:0] cr);
    ev_t e;
    e = '{busy: b, disp: d, cp: c, rej: r, credit: cr};
    q.push_back(e);
  endtask

  task automatic push_disp(input logic rej_first, input logic [3:0] cr);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b0, (i == 0) && rej_first, cr);
  endtask

  task automatic push_change(input int k);
    for (int i = k - 1; i >= 0; i--) begin
      push(1'b1, 1'b0, 1'b1, 1'b0, 4'(i));
      push(1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
    end
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c;
    step();
    coin = 2'b00;
  endtask

  // Wait (bounded) for all expected events, then idle a few cycles so stray events get caught.
  task automatic drain(input string nm);
    int b = 0;
    while (q.size() != 0 && b < 200) begin
      step();
      b++;
    end
    chk({nm, "_queue_left"}, 32'(q.size()), 32'd0);
    q.delete();
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b0; coin = 2'b00; sel_valid = 1'b0; cost = 3'd0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_outputs", 32'({dispense, change_pulse, reject, busy}), 32'd0);
    chk("rst_display", 32'(display), 32'h40);
    rst = 1'b1;
    step();

    // First coin from IDLE
    put_coin(2'b10);
    chk("coin2_credit", 32'(credit), 32'd2);
    chk("coin2_display", 32'(display), 32'h24);
    push_change(2);
    cancel = 1'b1; step(); cancel = 1'b0;
    drain("cancel2");
    chk("cancel2_credit", 32'(credit), 32'd0);

    // Exact pay: no change
    put_coin(2'b01);
    put_coin(2'b10);
    chk("exact_credit", 32'(credit), 32'd3);
    push_disp(1'b0, 4'd0);
    sel_valid = 1'b1; cost = 3'd3; step(); sel_valid = 1'b0;
    drain("exact");
    chk("exact_final", 32'(credit), 32'd0);

    // Overpay: 5 - 2 = 3 change, with a refused coin landing in the first gap
    put_coin(2'b11);
    chk("over_credit", 32'(credit), 32'd5);
    push_disp(1'b0, 4'd3);
    push(1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
    push(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    push(1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    push(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    sel_valid = 1'b1; cost = 3'd2; step(); sel_valid = 1'b0;
    repeat (4) step();
    put_coin(2'b10);
    drain("overpay");
    chk("over_final", 32'(credit), 32'd0);

    // Saturation at 14 and 15
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b10); put_coin(2'b10);
    chk("sat_credit14", 32'(credit), 32'd14);
    push(1'b0, 1'b0, 1'b0, 1'b1, 4'd14);
    put_coin(2'b10);
    chk("sat_held14", 32'(credit), 32'd14);
    put_coin(2'b01);
    chk("sat_credit15", 32'(credit), 32'd15);
    push(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    put_coin(2'b01);
    chk("sat_held15", 32'(credit), 32'd15);
    drain("saturate");

    // Coin colliding with a purchase: refused, 15 - 7 = 8 change
    push_disp(1'b1, 4'd8);
    push_change(8);
    sel_valid = 1'b1; cost = 3'd7; coin = 2'b01;
    step();
    sel_valid = 1'b0; coin = 2'b00;
    drain("collide");
    chk("collide_final", 32'(credit), 32'd0);

    // Cancel with credit 7: 7 pulses over 14 cycles
    put_coin(2'b11); put_coin(2'b10);
    chk("cancel7_credit", 32'(credit), 32'd7);
    push_change(7);
    cancel = 1'b1; step(); cancel = 1'b0;
    drain("cancel7");

    // Reset in the middle of DISPENSE
    put_coin(2'b11);
    push(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    push(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    sel_valid = 1'b1; cost = 3'd2; step(); sel_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_outputs", 32'({dispense, change_pulse, reject, busy}), 32'd0);
    chk("midrst_credit", 32'(credit), 32'd0);
    chk("midrst_display", 32'(display), 32'h40);
    step();
    rst = 1'b1;
    drain("midrst");
    chk("midrst_after", 32'(credit), 32'd0);

`ifdef PAYMENT_TIMEOUT_EN
    // Inactivity refund after 10 idle COLLECT cycles
    push_change(2);
    put_coin(2'b10);
    drain("timeout");
    chk("timeout_final", 32'(credit), 32'd0);
`else
    // Without the timeout credit is held
    put_coin(2'b10);
    repeat (100) step();
    chk("hold_credit", 32'(credit), 32'd2);
    chk("hold_busy", 32'(busy), 32'd0);
    push_change(2);
    cancel = 1'b1; step(); cancel = 1'b0;
    drain("hold_cancel");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
